mux_nto1_tdm: RTL and testbench

MUX_NTO1_TDM -- requirements
Module: mux_nto1_tdm

---
 rtl/mux_nto1_tdm.sv | 101 ++++++++++
 tb/tb_mux_nto1_tdm.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_tdm.sv
// mux_nto1_tdm: N-to-1 time-division mux with manual or round-robin select and a one-beat output register.
// Optional feature: define MUX_NTO1_TDM_PARITY_EN to add a registered out_parity output.
module mux_nto1_tdm #(
    parameter int WIDTH = 8,
    parameter int CH    = 8,
    parameter int SELW  = $clog2(CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH*WIDTH-1:0] in_data,
    input  logic [CH-1:0]       in_valid,
    output logic [CH-1:0]       in_ready,
    input  logic                mode,
    input  logic [SELW-1:0]     sel,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SELW-1:0]     out_ch
`ifdef MUX_NTO1_TDM_PARITY_EN
    ,
    output logic                out_parity
`endif
);

    logic [SELW-1:0]  ptr;
    logic             load;
    logic             man_ok;
    logic             scan_ok;
    logic [SELW-1:0]  scan_g;
    logic [CH-1:0]    rot;
    logic             gnt_ok;
    logic [SELW-1:0]  gnt;
    logic [WIDTH-1:0] gnt_data;

    assign load   = !out_valid || out_ready;
    assign gnt_ok = mode ? scan_ok : man_ok;
    assign gnt    = mode ? scan_g : sel;

    // Manual grant: sel must name an existing channel whose valid is high.
    always_comb begin
        man_ok = 1'b0;
        for (int k = 0; k < CH; k++) begin
            if (int'(sel) == k) man_ok = in_valid[k];
        end
    end

    // Scan grant: rotate valids so bit 0 is channel ptr+1, then take the lowest set bit.
    always_comb begin
        rot     = CH'({in_valid, in_valid} >> (int'(ptr) + 1));
        scan_ok = 1'b0;
        scan_g  = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                scan_ok = 1'b1;
                scan_g  = SELW'((int'(ptr) + 1 + i) % CH);
            end
        end
    end

    // Data of the granted channel.
    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < CH; k++) begin
            if (int'(gnt) == k) gnt_data = in_data[k*WIDTH +: WIDTH];
        end
    end

    // One-hot accept strobe, only when the output register can take a beat.
    always_comb begin
        in_ready = (load && gnt_ok) ? (CH'(1) << gnt) : '0;
    end

    // Output register; scan pointer only advances on scan-mode transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SELW'(CH - 1);
        end else if (load) begin
            out_valid <= gnt_ok;
            if (gnt_ok) begin
                out_data <= gnt_data;
                out_ch   <= gnt;
                if (mode) ptr <= gnt;
            end
        end
    end

`ifdef MUX_NTO1_TDM_PARITY_EN
    // Parity of the loaded beat, held with out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else if (load && gnt_ok) begin
            out_parity <= ^gnt_data;
        end
    end
`endif

endmodule

// File: tb/tb_mux_nto1_tdm.sv
// tb_mux_nto1_tdm: randomized self-checking bench for mux_nto1_tdm against a behavioural model.
module tb_mux_nto1_tdm;

    localparam int W = 8;
    localparam int N = 8;
    localparam int S = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic          mode;
    logic [S-1:0]  sel;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [S-1:0]  out_ch;
`ifdef MUX_NTO1_TDM_PARITY_EN
    logic          out_parity;
`endif

    int n_cmp = 0;
    int n_err = 0;

    bit       m_valid;
    bit [7:0] m_data;
    int       m_ch;
    int       m_ptr;
    bit       m_par;

    mux_nto1_tdm #(.WIDTH(W), .CH(N), .SELW(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
`ifdef MUX_NTO1_TDM_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    function automatic void ref_grant(output bit ok, output int g);
        int s;
        ok = 0;
        g  = 0;
        s  = int'(sel);
        if (!mode) begin
            if (s < N && in_valid[s]) begin
                ok = 1;
                g  = s;
            end
        end else begin
            for (int n = 1; n <= N; n++) begin
                int c;
                c = (m_ptr + n) % N;
                if (!ok && in_valid[c]) begin
                    ok = 1;
                    g  = c;
                end
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_ready();
        bit ok;
        int g;
        logic [N-1:0] r;
        ref_grant(ok, g);
        r = '0;
        if ((!m_valid || out_ready) && ok) r[g] = 1'b1;
        return r;
    endfunction

    function automatic void model_reset();
        m_valid = 0;
        m_data  = 0;
        m_ch    = 0;
        m_ptr   = N - 1;
        m_par   = 0;
    endfunction

    task automatic tick();
        bit ok;
        int g;
        bit ld;
        logic [7:0] d;
        ld = !m_valid || out_ready;
        ref_grant(ok, g);
        d = in_data[g*W +: W];
        @(posedge clk);
        if (ld) begin
            m_valid = ok;
            if (ok) begin
                m_data = d;
                m_ch   = g;
                m_par  = ^d;
                if (mode) m_ptr = g;
            end
        end
        #2;
    endtask

    task automatic set_ch(input int k, input logic [7:0] v);
        in_data[k*W +: W] = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        mode = 1'b0; sel = 4'd3; in_valid = 8'h08; out_ready = 1'b1;
        set_ch(3, 8'h5A);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || out_ch !== 4'd3) begin
            n_err++;
            $display("FAIL pre_reset_load: got v=%b d=%h ch=%0d want v=1 d=5a ch=3", out_valid, out_data, out_ch);
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 4'd0) begin
            n_err++;
            $display("FAIL async_reset: got v=%b d=%h ch=%0d want v=0 d=00 ch=0", out_valid, out_data, out_ch);
        end
`ifdef MUX_NTO1_TDM_PARITY_EN
        n_cmp++;
        if (out_parity !== 1'b0) begin
            n_err++;
            $display("FAIL reset_parity: got %b want 0", out_parity);
        end
`endif
        #1;
        rst_n = 1'b1;
        out_ready = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 8'h08) begin
            n_err++;
            $display("FAIL ready_after_reset: got %h want 08", in_ready);
        end
    endtask

    task automatic test_first_scan();
        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
        mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            logic [N-1:0] er;
            in_data = {$urandom, $urandom};
            #1;
            er = '0;
            er[i % N] = 1'b1;
            n_cmp++;
            if (in_ready !== er || in_ready !== exp_ready()) begin
                n_err++;
                $display("FAIL scan_ready[%0d]: got %h want %h", i, in_ready, er);
            end
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_ch !== S'(i % N) || out_data !== m_data) begin
                n_err++;
                $display("FAIL scan_out[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h", i, out_valid, out_ch, out_data, i % N, m_data);
            end
        end
    endtask

    task automatic test_manual();
        mode = 1'b0; sel = 4'd5; in_valid = 8'h20; out_ready = 1'b1;
        in_data = {$urandom, $urandom};
        set_ch(5, 8'hA5);
        #1;
        n_cmp++;
        if (in_ready !== 8'h20) begin
            n_err++;
            $display("FAIL manual_ready: got %h want 20", in_ready);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 4'd5) begin
            n_err++;
            $display("FAIL manual_out: got v=%b d=%h ch=%0d want v=1 d=a5 ch=5", out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_stall();
        logic [7:0] hd;
        logic [S-1:0] hc;
        hd = out_data;
        hc = out_ch;
        out_ready = 1'b0;
        in_valid = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            sel = S'(i);
            mode = i[0];
            in_data = {$urandom, $urandom};
            #1;
            n_cmp++;
            if (in_ready !== 8'h00) begin
                n_err++;
                $display("FAIL stall_ready[%0d]: got %h want 00", i, in_ready);
            end
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== hd || out_ch !== hc) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d", i, out_valid, out_data, out_ch, hd, hc);
            end
        end
        mode = 1'b0; sel = 4'd6; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 8'h40) begin
            n_err++;
            $display("FAIL stall_release_ready: got %h want 40", in_ready);
        end
        tick();
        n_cmp++;
        if (out_ch !== 4'd6 || out_data !== m_data) begin
            n_err++;
            $display("FAIL stall_release_out: got ch=%0d d=%h want ch=6 d=%h", out_ch, out_data, m_data);
        end
    endtask

    task automatic test_scan_skip();
        mode = 1'b1; out_ready = 1'b1; in_valid = 8'h04;
        tick();
        in_valid = 8'h81;
        for (int i = 0; i < 4; i++) begin
            int ec;
            ec = (i % 2 == 0) ? 7 : 0;
            in_data = {$urandom, $urandom};
            #1;
            n_cmp++;
            if ((in_ready & 8'h78) !== 8'h00 || in_ready !== (8'h01 << ec)) begin
                n_err++;
                $display("FAIL skip_ready[%0d]: got %h want %h", i, in_ready, 8'h01 << ec);
            end
            tick();
            n_cmp++;
            if (out_ch !== S'(ec) || out_data !== m_data) begin
                n_err++;
                $display("FAIL skip_out[%0d]: got ch=%0d d=%h want ch=%0d d=%h", i, out_ch, out_data, ec, m_data);
            end
        end
    endtask

    task automatic test_invalid_sel();
        logic [7:0] hd;
        hd = out_data;
        mode = 1'b0; sel = 4'd9; in_valid = 8'hFF; out_ready = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 8'h00) begin
            n_err++;
            $display("FAIL badsel_stall_ready: got %h want 00", in_ready);
        end
        tick();
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 8'h00) begin
            n_err++;
            $display("FAIL badsel_ready: got %h want 00", in_ready);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== hd) begin
            n_err++;
            $display("FAIL badsel_out: got v=%b d=%h want v=0 d=%h", out_valid, out_data, hd);
        end
    endtask

    task automatic test_midstall_reset();
        mode = 1'b0; sel = 4'd2; in_valid = 8'h04; out_ready = 1'b1;
        set_ch(2, 8'h3C);
        tick();
        out_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midstall_reset: got v=%b want 0", out_valid);
        end
        #1;
        rst_n = 1'b1;
        in_valid = 8'h00; out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL discarded_beat: got v=%b want 0", out_valid);
        end
`ifdef MUX_NTO1_TDM_PARITY_EN
        sel = 4'd0; in_valid = 8'h01;
        set_ch(0, 8'h07);
        tick();
        n_cmp++;
        if (out_parity !== 1'b1 || out_data !== 8'h07) begin
            n_err++;
            $display("FAIL parity_07: got p=%b d=%h want p=1 d=07", out_parity, out_data);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_data   = {$urandom, $urandom};
            in_valid  = (i % 3 == 0) ? N'($urandom & $urandom) : N'($urandom);
            mode      = 1'($urandom);
            sel       = S'($urandom_range(0, 9));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_cmp++;
            if (in_ready !== exp_ready()) begin
                n_err++;
                $display("FAIL rand_ready[%0d]: got %h want %h", i, in_ready, exp_ready());
            end
            tick();
            n_cmp++;
            if (out_valid !== m_valid || out_data !== m_data || out_ch !== S'(m_ch)) begin
                n_err++;
                $display("FAIL rand_out[%0d]: got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d", i, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
            end
`ifdef MUX_NTO1_TDM_PARITY_EN
            n_cmp++;
            if (out_parity !== m_par) begin
                n_err++;
                $display("FAIL rand_parity[%0d]: got %b want %b", i, out_parity, m_par);
            end
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b1;
        model_reset();
        #12;
        test_reset();
        test_first_scan();
        test_manual();
        test_stall();
        test_scan_skip();
        test_invalid_sel();
        test_midstall_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
